// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, shared types and window helper
package vga_timing_pkg;

    localparam int CNT_W = 10;
    localparam int DIV_W = 3;

    localparam int CE_DIV_DEF     = 2;
    localparam int SYNC_DELAY_DEF = 1;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int IMG_X0_DEF = 112;
    localparam int IMG_Y0_DEF = 13;
    localparam int IMG_W_DEF  = 400;
    localparam int IMG_H_DEF  = 400;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   span_t;
    typedef logic [DIV_W-1:0] div_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic sync;
    } sync_bus_t;

    localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, sync: 1'b1};

    // Upper bound is widened by one bit so lo+len can reach 1024 without wrapping.
    function automatic logic in_span(cnt_t x, cnt_t lo, span_t len);
        return (x >= lo) && ({1'b0, x} < ({1'b0, lo} + len));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing generator outputs towards the drawer and the DAC
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic pix_ce;
    cnt_t hcount;
    cnt_t vcount;
    logic bounds_draw;
    logic frame_start;
    logic hsync;
    logic vsync;
    logic blank_n;
    logic sync_n;

    modport master (
        output pix_ce, hcount, vcount, bounds_draw, frame_start,
        output hsync, vsync, blank_n, sync_n
    );

    modport slave (
        input pix_ce, hcount, vcount, bounds_draw, frame_start,
        input hsync, vsync, blank_n, sync_n
    );

endinterface

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - pixel-tick gated shift register, DEPTH=0 is a wire
module sync_delay_line #(
    parameter int            DEPTH     = 1,
    parameter int            W         = 4,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst_n, ce};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] stage_q [DEPTH];
            logic [W-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d = stage_q;
                if (ce) begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-tick divider, scan counters, image window and delayed syncs
module vga_timing_gen #(
    parameter int CE_DIV     = vga_timing_pkg::CE_DIV_DEF,
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int IMG_X0     = vga_timing_pkg::IMG_X0_DEF,
    parameter int IMG_Y0     = vga_timing_pkg::IMG_Y0_DEF,
    parameter int IMG_W      = vga_timing_pkg::IMG_W_DEF,
    parameter int IMG_H      = vga_timing_pkg::IMG_H_DEF,
    parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam div_t  DIV_LAST = div_t'(CE_DIV - 1);
    localparam cnt_t  H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t  V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t  HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t  VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam span_t HS_LEN   = span_t'(H_SYNC);
    localparam span_t VS_LEN   = span_t'(V_SYNC);
    localparam span_t H_VIS    = span_t'(H_VISIBLE);
    localparam span_t V_VIS    = span_t'(V_VISIBLE);
    localparam cnt_t  X0       = cnt_t'(IMG_X0);
    localparam cnt_t  Y0       = cnt_t'(IMG_Y0);
    localparam span_t WIN_W    = span_t'(IMG_W);
    localparam span_t WIN_H    = span_t'(IMG_H);

    div_t      div_q, div_d;
    logic      pix_ce_q, pix_ce_d;
    cnt_t      hcount_q, hcount_d;
    cnt_t      vcount_q, vcount_d;
    logic      frame_start_q, frame_start_d;
    sync_bus_t raw;
    sync_bus_t del;
    logic      bounds_draw;

    // pix_ce is registered so it stays low through reset even when CE_DIV=1;
    // the first tick therefore lands CE_DIV clocks after release.
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_ce_d      = (div_q == DIV_LAST);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (pix_ce_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        raw       = SYNC_IDLE;
        raw.hs    = ~in_span(hcount_q, HS_START, HS_LEN);
        raw.vs    = ~in_span(vcount_q, VS_START, VS_LEN);
        raw.blank = in_span(hcount_q, '0, H_VIS) && in_span(vcount_q, '0, V_VIS);
        raw.sync  = raw.hs & raw.vs;
        bounds_draw = in_span(hcount_q, X0, WIN_W) && in_span(vcount_q, Y0, WIN_H);
    end

    // Shifting on the same tick as the counters keeps the syncs aligned with
    // the drawer's registered pixel, SYNC_DELAY ticks behind hcount/vcount.
    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .W         (4),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (pix_ce_q),
        .din   (raw),
        .dout  (del)
    );

    assign vga.pix_ce      = pix_ce_q;
    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.bounds_draw = bounds_draw;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = del.hs;
    assign vga.vsync       = del.vs;
    assign vga.blank_n     = del.blank;
    assign vga.sync_n      = del.sync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks on four configurations plus a small-frame scoreboard
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int S_CE = 2;
    localparam int S_HV = 64, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 48, S_VF = 2, S_VS = 2, S_VB = 4;
    localparam int S_X0 = 10, S_Y0 = 3, S_W = 40, S_H = 40;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic ce, fs, bd, hs, vs, bl, sn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_s;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_small ();
    vga_timing_gen_if if_fast ();
    vga_timing_gen_if if_ce4 ();

    vga_timing_gen u_def (.clk(clk), .rst_n(rst_n), .vga(if_def));

    vga_timing_gen #(
        .CE_DIV(S_CE), .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .IMG_X0(S_X0), .IMG_Y0(S_Y0), .IMG_W(S_W), .IMG_H(S_H), .SYNC_DELAY(1)
    ) u_small (.clk(clk), .rst_n(rst_s), .vga(if_small));

    vga_timing_gen #(.CE_DIV(1), .SYNC_DELAY(0)) u_fast (.clk(clk), .rst_n(rst_n), .vga(if_fast));

    vga_timing_gen #(.CE_DIV(4)) u_ce4 (.clk(clk), .rst_n(rst_n), .vga(if_ce4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_def(input logic [9:0] h, input logic [9:0] v, input int budget, input string tag);
        int k = 0;
        while (!(if_def.hcount == h && if_def.vcount == v) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < budget), 1);
    endtask

    // Expected small-config state after c clocks since release, from pure tick arithmetic.
    function automatic exp_t model(input int c);
        exp_t e;
        int t, p, hx, vy;
        t    = (c >= 1) ? (c - 1) / S_CE : 0;
        e.h  = 10'(t % S_HT);
        e.v  = 10'((t / S_HT) % S_VT);
        e.ce = (c >= 1) && (c % S_CE == 0);
        e.fs = (c >= 2) && ((c - 1) % S_CE == 0) && (t > 0) && (t % (S_HT * S_VT) == 0);
        e.bd = (int'(e.h) >= S_X0) && (int'(e.h) < S_X0 + S_W) &&
               (int'(e.v) >= S_Y0) && (int'(e.v) < S_Y0 + S_H);
        if (t == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.sn = 1'b1;
        end else begin
            p    = t - 1;
            hx   = p % S_HT;
            vy   = (p / S_HT) % S_VT;
            e.hs = !(hx >= S_HV + S_HF && hx < S_HV + S_HF + S_HS);
            e.vs = !(vy >= S_VV + S_VF && vy < S_VV + S_VF + S_VS);
            e.bl = (hx < S_HV) && (vy < S_VV);
            e.sn = e.hs & e.vs;
        end
        return e;
    endfunction

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            if (!rst_s) c = 0;
            else c++;
            sb_q.push_back(model(c));
        end
    end

    initial begin
        exp_t e, o;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                o = '{h: if_small.hcount, v: if_small.vcount, ce: if_small.pix_ce,
                      fs: if_small.frame_start, bd: if_small.bounds_draw, hs: if_small.hsync,
                      vs: if_small.vsync, bl: if_small.blank_n, sn: if_small.sync_n};
                check("small_sb", 32'(o), 32'(e));
            end
        end
    end

    initial begin
        int k, n, nf, last, gap, gmin, gmax;
        int fs_n, vs_n, bl_n, bd_n;
        rst_n = 1'b0;
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hcount", 32'(if_def.hcount), 0);
        check("rst_vcount", 32'(if_def.vcount), 0);
        check("rst_hsync", 32'(if_def.hsync), 1);
        check("rst_vsync", 32'(if_def.vsync), 1);
        check("rst_blank_n", 32'(if_def.blank_n), 0);
        check("rst_sync_n", 32'(if_def.sync_n), 1);
        check("rst_pix_ce", 32'(if_def.pix_ce), 0);
        check("rst_frame_start", 32'(if_def.frame_start), 0);
        check("rst_bounds", 32'(if_def.bounds_draw), 0);
        check("rst_fast_pix_ce", 32'(if_fast.pix_ce), 0);

        rst_n = 1'b1;
        rst_s = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!if_def.pix_ce && k < 20);
        check("first_ce_latency", 32'(k), 2);

        n = 0; nf = 0; last = -1; gmin = 1000; gmax = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (if_fast.pix_ce) nf++;
            if (if_ce4.pix_ce) begin
                n++;
                if (last >= 0) begin
                    gap  = i - last;
                    gmin = (gap < gmin) ? gap : gmin;
                    gmax = (gap > gmax) ? gap : gmax;
                end
                last = i;
            end
        end
        check("ce4_count", 32'(n), 100);
        check("ce4_gap_min", 32'(gmin), 4);
        check("ce4_gap_max", 32'(gmax), 4);
        check("fast_ce_always", 32'(nf), 400);

        k = 0;
        while (if_fast.hcount != 10'd655 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("fast_wait_655", 32'(k < 2000), 1);
        check("fast_hsync_655", 32'(if_fast.hsync), 1);
        @(negedge clk);
        check("fast_hcount_656", 32'(if_fast.hcount), 656);
        check("fast_hsync_656", 32'(if_fast.hsync), 0);

        k = 0;
        while (if_def.hsync !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("def_hs_fall_wait", 32'(k < 4000), 1);
        check("def_hs_fall_h", 32'(if_def.hcount), 657);
        check("def_hs_fall_v", 32'(if_def.vcount), 0);
        n = 0; k = 0;
        while (if_def.hsync === 1'b0 && k < 4000) begin
            if (if_def.pix_ce) n++;
            @(negedge clk);
            k++;
        end
        check("def_hs_width", 32'(n), 96);
        check("def_hs_rise_h", 32'(if_def.hcount), 753);

        wait_def(10'd799, 10'd0, 4000, "def_wait_799");
        k = 0;
        while (if_def.hcount == 10'd799 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("def_wrap_h", 32'(if_def.hcount), 0);
        check("def_wrap_v", 32'(if_def.vcount), 1);

        fs_n = 0; vs_n = 0; bl_n = 0; bd_n = 0;
        repeat (S_HT * S_VT * S_CE) begin
            @(negedge clk);
            if (if_small.frame_start) fs_n++;
            if (if_small.pix_ce) begin
                if (!if_small.vsync) vs_n++;
                if (if_small.blank_n) bl_n++;
                if (if_small.bounds_draw) bd_n++;
            end
        end
        check("small_frame_starts", 32'(fs_n), 1);
        check("small_vsync_ticks", 32'(vs_n), 32'(S_VS * S_HT));
        check("small_blank_ticks", 32'(bl_n), 32'(S_HV * S_VV));
        check("small_bounds_ticks", 32'(bd_n), 32'(S_W * S_H));

        k = 0;
        while (!(if_small.hcount == 10'd30 && if_small.vcount == 10'd20) && k < S_HT * S_VT * S_CE + 10) begin
            @(negedge clk);
            k++;
        end
        check("small_wait_30_20", 32'(k < S_HT * S_VT * S_CE + 10), 1);
        rst_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_frame_start", 32'(if_small.frame_start), 0);
            check("midrst_hcount", 32'(if_small.hcount), 0);
            check("midrst_vcount", 32'(if_small.vcount), 0);
        end
        rst_s = 1'b1;
        repeat (200) @(negedge clk);

        wait_def(10'd111, 10'd13, 30000, "def_wait_111_13");
        check("def_bounds_111", 32'(if_def.bounds_draw), 0);
        wait_def(10'd112, 10'd13, 10, "def_wait_112_13");
        check("def_bounds_112", 32'(if_def.bounds_draw), 1);
        wait_def(10'd511, 10'd13, 1000, "def_wait_511_13");
        check("def_bounds_511", 32'(if_def.bounds_draw), 1);
        wait_def(10'd512, 10'd13, 10, "def_wait_512_13");
        check("def_bounds_512", 32'(if_def.bounds_draw), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
